cpu_mc: RTL and testbench
=========================

# cpu_mc

Parametrised multi-cycle successor to the single-cycle 16-bit core. It keeps the 4×4-bit instruction format (src1, src2, dest, func) and adds load/store, a conditional relative branch and a halt instruction. It runs a fetch/decode/execute/memory state machine over one shared memory port with a req/ack handshake, so it tolerates variable-latency memory. It sits at the top of the compute path and talks to a single external memory or bus adapter.

## Interface
- `DATA_W`, default 16: register/ALU/memory data width; must be ≥16.
- `ADDR_W`, default 12: memory word-address width and PC width.
- `RESET_PC`, default 0: PC value loaded on reset.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `mem_req`  out  1  memory transaction request.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  DATA_W  store data.
- `mem_rdata`  in  DATA_W  read data; sampled on the `mem_ack` edge.
- `mem_ack`  in  1  transaction complete.
- `halted`  out  1  core stopped on HALT.

## Operation
- Instruction bit fields: [15:12] src1, [11:8] src2, [7:4] dest, [3:0] func. The instruction is `mem_rdata[15:0]`; upper data bits are ignored on fetch.
- 16 registers. r0 always reads 0 and writes to r0 are discarded.
- ALU funcs, result written to reg[dest], a=reg[src1], b=reg[src2], all mod 2^DATA_W:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 NOT a.
  - 6 SHL a by b[3:0]; 7 SHR logical; 8 SRA.
  - 9 SLT signed → 1/0; 10 SLTU unsigned → 1/0.
  - 11 MOV a.
- 12 LD: reg[dest] ← mem[reg[src1][ADDR_W-1:0]].
- 13 ST: mem[reg[src1][ADDR_W-1:0]] ← reg[src2].
- 14 BRZ: if reg[src1]==0 then PC ← PC_next + sext({src2,dest}), an 8-bit two's-complement offset; otherwise PC unchanged.
- 15 HALT: enter HALT state.
- PC arithmetic is mod 2^ADDR_W and wraps silently (0xFFF+1 → 0x000 at ADDR_W=12).
- FSM states:
  - FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=PC. Hold until ack. On the ack edge: IR ← rdata, PC ← PC+1, go to DECODE.
  - DECODE: latch A=reg[src1], B=reg[src2]. Go to EXEC.
  - EXEC:
    - ALU op: write dest, go to FETCH.
    - BRZ: update PC, go to FETCH.
    - LD/ST: latch address, go to MEM.
    - HALT: go to HALT.
  - MEM: `mem_req`=1, `mem_we`=(func==ST), `mem_wdata`=B. Hold until ack. On ack: LD writes dest; go to FETCH.
  - HALT: no requests, `halted`=1, stays there until reset.
- Register writes complete in EXEC/MEM, so DECODE of the next instruction always sees them (no hazards).

## Timing
- Reset (asynchronous assert) clears:
  - state → FETCH, PC → RESET_PC.
  - IR, A, B → 0; all registers → 0.
  - `mem_req`=0 while reset is asserted, `halted`=0.
- First request is the first cycle after deassert.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are decoded from registered state only and stay stable for the whole request.
- Zero-wait memory may assert `mem_ack` in the same cycle as `mem_req`; the transaction then completes at that edge.
- `mem_ack` is ignored when `mem_req`=0.
- `mem_req` drops for at least one cycle between transactions; the DECODE/EXEC cycles guarantee this.
- Latency with zero-wait memory:
  - ALU, BRZ, HALT: 3 cycles.
  - LD, ST: 4 cycles.
  - Each wait cycle on ack adds 1.
- Reset asserted mid-transaction: the request is abandoned immediately and no register or PC update occurs.

## Structure
- `cpu_mc_pkg` holds the func codes (enum), FSM state enum, and field-position constants.
- One sub-module, `reg_file_p`: 16×DATA_W, two asynchronous read ports, one synchronous write port, r0 hardwired to zero.
- The ALU stays inline as a case on func.

## Test plan
- ALU sequence, zero-wait memory, DATA_W=16:
  - stimulus: mem[0x10]=7, mem[0x11]=5; r1=0x10; LD r2,(r1); r1=0x11 via ADD-from-zero; LD r3; ADD r4=r2+r3; ST r4→(r1).
  - required: mem[0x11]=12; each ALU op takes 3 cycles, each LD/ST 4.
- Wait states: ack delayed 3 cycles on every transaction.
  - required: `mem_addr`, `mem_we` and `mem_wdata` stable throughout; results identical to the zero-wait run; cycle count +3 per transaction.
- BRZ:
  - taken with offset 0xFE (−2) at PC 0x020 → next fetch at 0x01F.
  - not taken (reg≠0) → next fetch at 0x021.
  - taken at PC 0xFFF with offset +1 → next fetch at 0x001 (wrap).
- SLT/SRA signed, with 0x8000 vs 0x0001:
  - SLT → 1, SLTU → 0.
  - SRA 0x8000 by 3 → 0xF000.
  - write to r0, then read r0 → 0.
- HALT: `halted`=1 on the cycle after EXEC; no `mem_req` for 20 cycles; reset restarts fetch at RESET_PC.
- Reset asserted while MEM waits on a ST: no write occurs (`mem_req` drops asynchronously); after release, fetch resumes at RESET_PC with all registers 0.

Source files
------------

// File: rtl/cpu_mc_pkg.sv
// rtl/cpu_mc_pkg.sv - shared types and constants for the multi-cycle core
package cpu_mc_pkg;

  // Instruction func codes (low nibble of the instruction word)
  typedef enum logic [3:0] {
    F_ADD  = 4'd0,
    F_SUB  = 4'd1,
    F_AND  = 4'd2,
    F_OR   = 4'd3,
    F_XOR  = 4'd4,
    F_NOT  = 4'd5,
    F_SHL  = 4'd6,
    F_SHR  = 4'd7,
    F_SRA  = 4'd8,
    F_SLT  = 4'd9,
    F_SLTU = 4'd10,
    F_MOV  = 4'd11,
    F_LD   = 4'd12,
    F_ST   = 4'd13,
    F_BRZ  = 4'd14,
    F_HALT = 4'd15
  } func_e;

  // Sequencer states
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  // Instruction field positions, each field 4 bits wide
  localparam int FIELD_W  = 4;
  localparam int SRC1_LSB = 12;
  localparam int SRC2_LSB = 8;
  localparam int DEST_LSB = 4;
  localparam int FUNC_LSB = 0;
  localparam int INSN_W   = 16;

  // Branch offset spans {src2,dest}
  localparam int OFF_LSB  = 4;
  localparam int OFF_W    = 8;

  localparam int NUM_REGS = 16;

endpackage

// File: rtl/cpu_mc_reg_file.sv
// rtl/cpu_mc_reg_file.sv - 16-entry register file, two async reads, one sync write, r0 = 0
module reg_file_p
  import cpu_mc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [FIELD_W-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [FIELD_W-1:0] raddr1,
  output logic [DATA_W-1:0]  rdata1,
  input  logic [FIELD_W-1:0] raddr2,
  output logic [DATA_W-1:0]  rdata2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Register storage; writes aimed at r0 are dropped so it stays zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/cpu_mc.sv
// rtl/cpu_mc.sv - multi-cycle 16-func core with shared req/ack memory port
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q;
  logic [INSN_W-1:0]   ir_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [ADDR_W-1:0]   addr_q;

  logic [FIELD_W-1:0]  src1, src2, dest;
  func_e               func;
  logic [OFF_W-1:0]    br_off;
  logic [ADDR_W-1:0]   br_target;

  logic [DATA_W-1:0]   rd1, rd2;
  logic [DATA_W-1:0]   alu_y;
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata;
  logic                req_c;

  assign src1      = ir_q[SRC1_LSB +: FIELD_W];
  assign src2      = ir_q[SRC2_LSB +: FIELD_W];
  assign dest      = ir_q[DEST_LSB +: FIELD_W];
  assign func      = func_e'(ir_q[FUNC_LSB +: FIELD_W]);
  assign br_off    = ir_q[OFF_LSB +: OFF_W];
  // pc_q already holds PC+1 by EXEC, so the offset is relative to the next instruction
  assign br_target = pc_q + ADDR_W'($signed(br_off));

  reg_file_p #(.DATA_W(DATA_W)) u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (rf_we),
    .waddr  (dest),
    .wdata  (rf_wdata),
    .raddr1 (src1),
    .rdata1 (rd1),
    .raddr2 (src2),
    .rdata2 (rd2)
  );

  // ALU: pure function of the latched operands and func
  always_comb begin
    alu_y = '0;
    case (func)
      F_ADD:   alu_y = a_q + b_q;
      F_SUB:   alu_y = a_q - b_q;
      F_AND:   alu_y = a_q & b_q;
      F_OR:    alu_y = a_q | b_q;
      F_XOR:   alu_y = a_q ^ b_q;
      F_NOT:   alu_y = ~a_q;
      F_SHL:   alu_y = a_q << b_q[3:0];
      F_SHR:   alu_y = a_q >> b_q[3:0];
      F_SRA:   alu_y = DATA_W'($signed(a_q) >>> b_q[3:0]);
      F_SLT:   alu_y = DATA_W'($signed(a_q) < $signed(b_q));
      F_SLTU:  alu_y = DATA_W'(a_q < b_q);
      F_MOV:   alu_y = a_q;
      default: alu_y = '0;
    endcase
  end

  // Next-state, memory port and register-write decode from registered state
  always_comb begin
    state_d  = state_q;
    req_c    = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q;
    rf_we    = 1'b0;
    rf_wdata = alu_y;
    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ack) state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (func)
          F_LD, F_ST: state_d = S_MEM;
          F_BRZ:      state_d = S_FETCH;
          F_HALT:     state_d = S_HALT;
          default: begin
            rf_we   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        req_c    = 1'b1;
        mem_we   = (func == F_ST);
        mem_addr = addr_q;
        if (mem_ack) begin
          rf_we    = (func == F_LD);
          rf_wdata = mem_rdata;
          state_d  = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces the request low at once, abandoning any transaction in flight
  assign mem_req   = req_c & reset;
  assign mem_wdata = b_q;
  assign halted    = (state_q == S_HALT);

  // Sequencer state, PC, instruction and operand registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_FETCH: begin
          if (mem_ack) begin
            ir_q <= mem_rdata[INSN_W-1:0];
            pc_q <= pc_q + 1'b1;
          end
        end
        S_DECODE: begin
          a_q <= rd1;
          b_q <= rd2;
        end
        S_EXEC: begin
          if (func == F_BRZ && a_q == '0) pc_q <= br_target;
          if (func == F_LD || func == F_ST) addr_q <= a_q[ADDR_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mc.sv
// tb/tb_cpu_mc.sv - directed self-checking bench for cpu_mc
module tb_cpu_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ack, halted;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  cpu_mc #(.DATA_W(16), .ADDR_W(12), .RESET_PC(12'h000)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Memory image, written only by the stimulus block; DUT stores are logged instead
  logic [15:0] mem [4096];
  int          wait_n = 0;
  int          wcnt = 0;
  logic        log_clr = 1'b1;

  logic [11:0] wr_addr_log [16];
  logic [15:0] wr_data_log [16];
  int          wr_cnt = 0;
  logic [11:0] rd_log [64];
  int          rd_cnt = 0;

  int          stab_err = 0;
  logic        pend = 1'b0;
  logic [11:0] p_addr = '0;
  logic        p_we = 1'b0;
  logic [15:0] p_wdata = '0;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && (wcnt == wait_n);

  // Memory responder: wait-state counter, transaction log, request stability monitor
  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
    if (log_clr) begin
      wr_cnt <= 0;
      rd_cnt <= 0;
    end else if (mem_req && mem_ack) begin
      if (mem_we) begin
        if (wr_cnt < 16) begin
          wr_addr_log[wr_cnt] <= mem_addr;
          wr_data_log[wr_cnt] <= mem_wdata;
        end
        wr_cnt <= wr_cnt + 1;
      end else begin
        if (rd_cnt < 64) rd_log[rd_cnt] <= mem_addr;
        rd_cnt <= rd_cnt + 1;
      end
    end
    if (mem_req && pend && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
      stab_err <= stab_err + 1;
    pend    <= mem_req && !mem_ack;
    p_addr  <= mem_addr;
    p_we    <= mem_we;
    p_wdata <= mem_wdata;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset   = 1'b0;
    log_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic release_reset(input int waits);
    wait_n  = waits;
    log_clr = 1'b0;
    reset   = 1'b1;
  endtask

  task automatic run_to_halt(output int cyc);
    cyc = 0;
    while (halted !== 1'b1 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Build 0x10 from scratch, load 7 and 5, add, store 12 at 0x11, halt
  task automatic load_prog1();
    clear_mem();
    mem[0]  = 16'h0055;  // NOT r5 = ~r0
    mem[1]  = 16'h0561;  // SUB r6 = r0 - r5 = 1
    mem[2]  = 16'h6670;  // ADD r7 = r6 + r6 = 2
    mem[3]  = 16'h7770;  // ADD r7 = r7 + r7 = 4
    mem[4]  = 16'h6716;  // SHL r1 = r6 << r7 = 0x10
    mem[5]  = 16'h102C;  // LD r2, (r1)
    mem[6]  = 16'h1610;  // ADD r1 = r1 + r6 = 0x11
    mem[7]  = 16'h103C;  // LD r3, (r1)
    mem[8]  = 16'h2340;  // ADD r4 = r2 + r3
    mem[9]  = 16'h140D;  // ST r4, (r1)
    mem[10] = 16'h000F;  // HALT
    mem[12'h010] = 16'd7;
    mem[12'h011] = 16'd5;
  endtask

  int cyc, t, req_seen;

  initial begin
    reset = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_halted", halted, 1'b0);

    // ---- ALU / LD / ST program, zero-wait memory
    load_prog1();
    @(negedge clk);
    @(negedge clk);
    release_reset(0);
    #1;
    chk("first_req", mem_req, 1'b1);
    chk("first_addr", mem_addr, 12'h000);
    run_to_halt(cyc);
    chk("p1_cycles", cyc, 36);
    chk("p1_wr_cnt", wr_cnt, 1);
    chk("p1_wr_addr", wr_addr_log[0], 12'h011);
    chk("p1_wr_data", wr_data_log[0], 16'h000C);
    chk("p1_rd_cnt", rd_cnt, 13);
    req_seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (mem_req !== 1'b0) req_seen++;
    end
    chk("halt_idle_req", req_seen, 0);
    chk("halt_stays", halted, 1'b1);

    // ---- same program, three wait states per transaction
    hold_reset();
    chk("halt_rst_clr", halted, 1'b0);
    chk("halt_rst_req", mem_req, 1'b0);
    load_prog1();
    release_reset(3);
    run_to_halt(cyc);
    chk("p1w_cycles", cyc, 78);
    chk("p1w_wr_cnt", wr_cnt, 1);
    chk("p1w_wr_addr", wr_addr_log[0], 12'h011);
    chk("p1w_wr_data", wr_data_log[0], 16'h000C);
    chk("p1w_stable", stab_err, 0);

    // ---- signed compare, shifts, r0 write
    hold_reset();
    clear_mem();
    mem[0]  = 16'h001C;  // LD r1, (r0): r1 = this word = 0x1C
    mem[1]  = 16'h102C;  // LD r2, (r1) = 0x8000
    mem[2]  = 16'h0055;  // NOT r5 = 0xFFFF
    mem[3]  = 16'h0561;  // SUB r6 = 1
    mem[4]  = 16'h2679;  // SLT r7 = r2 < r6
    mem[5]  = 16'h268A;  // SLTU r8 = r2 < r6
    mem[6]  = 16'h6690;  // ADD r9 = 2
    mem[7]  = 16'h9690;  // ADD r9 = 3
    mem[8]  = 16'h29A8;  // SRA r10 = r2 >>> 3
    mem[9]  = 16'h29B7;  // SHR r11 = r2 >> 3
    mem[10] = 16'h6600;  // ADD r0 = 2 (discarded)
    mem[11] = 16'h670D;  // ST r7, (r6)
    mem[12] = 16'h980D;  // ST r8, (r9)
    mem[13] = 16'h1A0D;  // ST r10, (r1)
    mem[14] = 16'h200D;  // ST r0, (r2)
    mem[15] = 16'h5B0D;  // ST r11, (r5)
    mem[16] = 16'h000F;  // HALT
    mem[12'h01C] = 16'h8000;
    release_reset(0);
    run_to_halt(cyc);
    chk("p2_halted", halted, 1'b1);
    chk("p2_wr_cnt", wr_cnt, 5);
    chk("slt_addr", wr_addr_log[0], 12'h001);
    chk("slt_data", wr_data_log[0], 16'h0001);
    chk("sltu_addr", wr_addr_log[1], 12'h003);
    chk("sltu_data", wr_data_log[1], 16'h0000);
    chk("sra_addr", wr_addr_log[2], 12'h01C);
    chk("sra_data", wr_data_log[2], 16'hF000);
    chk("r0_addr", wr_addr_log[3], 12'h000);
    chk("r0_data", wr_data_log[3], 16'h0000);
    chk("shr_addr", wr_addr_log[4], 12'hFFF);
    chk("shr_data", wr_data_log[4], 16'h1000);

    // ---- BRZ taken backwards, not taken, taken across the PC wrap
    hold_reset();
    clear_mem();
    mem[12'h000] = 16'h01FE;  // BRZ r0, +0x1F -> 0x020
    mem[12'h001] = 16'h000F;  // HALT
    mem[12'h01F] = 16'h0065;  // NOT r6 = 0xFFFF
    mem[12'h020] = 16'h6FEE;  // BRZ r6, -2
    mem[12'h021] = 16'h0DDE;  // BRZ r0, -35 -> 0xFFF
    mem[12'hFFF] = 16'h001E;  // BRZ r0, +1 -> 0x001
    release_reset(0);
    run_to_halt(cyc);
    chk("br_cycles", cyc, 21);
    chk("br_rd_cnt", rd_cnt, 7);
    chk("br_f0", rd_log[0], 12'h000);
    chk("br_f1", rd_log[1], 12'h020);
    chk("br_taken_back", rd_log[2], 12'h01F);
    chk("br_f3", rd_log[3], 12'h020);
    chk("br_not_taken", rd_log[4], 12'h021);
    chk("br_f5", rd_log[5], 12'hFFF);
    chk("br_wrap", rd_log[6], 12'h001);

    // ---- reset while a store waits for ack
    hold_reset();
    load_prog1();
    release_reset(3);
    t = 0;
    while (!(mem_req === 1'b1 && mem_we === 1'b1) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("st_reached", mem_we, 1'b1);
    chk("st_addr", mem_addr, 12'h011);
    reset = 1'b0;
    #1;
    chk("st_abort_req", mem_req, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("st_abort_nowr", wr_cnt, 0);
    log_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear_mem();
    mem[0] = 16'h010D;  // ST r1, (r0)
    mem[1] = 16'h020D;  // ST r2, (r0)
    mem[2] = 16'h030D;  // ST r3, (r0)
    mem[3] = 16'h040D;  // ST r4, (r0)
    mem[4] = 16'h050D;  // ST r5, (r0)
    mem[5] = 16'h060D;  // ST r6, (r0)
    mem[6] = 16'h000F;  // HALT
    release_reset(0);
    run_to_halt(cyc);
    chk("p5_cycles", cyc, 27);
    chk("p5_first_fetch", rd_log[0], 12'h000);
    chk("p5_wr_cnt", wr_cnt, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("p5_addr%0d", i), wr_addr_log[i], 12'h000);
      chk($sformatf("p5_data%0d", i), wr_data_log[i], 16'h0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
